kernel_buffer_ctrl: RTL
=======================

# kernel_buffer_ctrl

Sequencer for the kernel buffer: streams kernel words in over a valid/ready port, scatters them round-robin across the D banks through the packed `ioInputs` control bus, then walks the read address for the convolution unit with a stall input and an aligned row-valid strobe. Sits between the kernel DMA/stream source and the kernel buffer; it is the only driver of the buffer's `address` and `ioInputs` ports.

## Interface
- `depth`, 2, log2 of convolutional-unit size; `D = 1<<depth` banks.
- `A`, 7, buffer address width.
- `W`, 16, kernel word width.
- `CLK`  in  1  clock, all state on rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `load_start`  in  1  begin load (sampled in IDLE only).
- `load_base`  in  A  first row address of load.
- `load_rows`  in  A+1  rows to load (D words per row).
- `in_data`  in  W  kernel word.
- `in_valid`  in  1  word present.
- `in_ready`  out  1  word accepted when `in_valid & in_ready`.
- `read_start`  in  1  begin read (sampled in IDLE only).
- `read_base`  in  A  first row to read.
- `read_rows`  in  A+1  rows to read.
- `read_advance`  in  1  consumer takes the current row this cycle.
- `address`  out  A  buffer row address.
- `ioInputs`  out  W+depth+2  {ioSelect, ioWrite, bank[depth-1:0], data[W-1:0]}, MSB first.
- `row_valid`  out  1  buffer `op` holds a requested row.
- `load_done`, `read_done`  out  1  one-cycle pulses.
- `busy`  out  1  state != IDLE.

## Operation
- States: IDLE, LOAD, LOAD_FLUSH, READ, DRAIN.
- IDLE: `load_start` -> LOAD (row=`load_base`, bank=0, count=`load_rows`); else `read_start` -> READ. Both high: load wins, read request dropped. Rows=0: no transfer, matching done pulse next cycle, stay IDLE.
- LOAD: `in_ready`=1. Each handshake registers a write: next cycle `ioSelect`=1, `ioWrite`=1, bank=current bank, data=`in_data`, `address`=current row. Bank increments mod D; on wrap, row increments mod 2^A and count decrements. Final word -> LOAD_FLUSH.
- LOAD_FLUSH: last write is on the bus; `in_ready`=0; `load_done` pulses; -> IDLE.
- READ: `ioSelect`=0, `ioWrite`=0, `address`=current row. `read_advance`=1 consumes the row: `row_valid`=1 next cycle, row+1 mod 2^A, count-1. `read_advance`=0 holds address; `row_valid` 0 next cycle. Last consume -> DRAIN.
- DRAIN: `row_valid`=1 and `read_done`=1 together (last row); -> IDLE.
- Start pulses outside IDLE ignored. Reset mid-operation aborts; rows already written stay in the buffer, no done pulse.

## Timing
- Reset values: `address`=0, `ioInputs`=0 (ioWrite=0, ioSelect=0), `in_ready`=0, `row_valid`=0, done pulses 0, `busy`=0, state IDLE.
- All outputs registered except `in_ready` and `busy` (decoded from state).
- Write latency: handshake at edge N -> write fields on bus during cycle N+1 -> buffer captures at edge N+2.
- Read latency: 1 cycle; address consumed at edge N -> `row_valid` and `op` valid during cycle N+1.
- Load throughput 1 word/cycle; read throughput 1 row/cycle. Outside active writes `ioWrite`=0.

## Structure
- Package `kernel_buffer_pkg`: state enum, `ioInputs` field offsets (data LSB 0, bank at W, ioWrite at W+depth, ioSelect at W+depth+1).
- One sub-module `kb_row_counter`: loadable A-bit wrap address plus A+1-bit down-count with `last` flag; instantiated once, shared by LOAD and READ (never active together).

## Test plan
- Reset mid-LOAD after 5 words -> outputs at reset values next cycle, no `load_done`; subsequent `read_start` works.
- Load `load_base`=3, `load_rows`=2, words 0x0100..0x0107 back-to-back -> bus writes bank 0..3 at row 3 then row 4, data in order; `load_done` one cycle after last write.
- Same load with `in_valid` toggling every other cycle -> identical write sequence, no gaps mis-banked.
- Read `read_base`=126, `read_rows`=4 -> addresses 126,127,0,1; `row_valid` one cycle after each; `read_done` with 4th.
- Read with `read_advance` low for 3 cycles mid-stream -> address held, `row_valid` low during stall, no skipped/duplicated rows.
- `load_start`+`read_start` same cycle -> load only; `load_rows`=0 -> `load_done` next cycle, no `ioWrite`.

Source files
------------

// File: rtl/kernel_buffer_pkg.sv
// Shared types and ioInputs bus layout for the kernel buffer sequencer.
package kernel_buffer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StLoadFlush,
    StRead,
    StDrain
  } kb_state_e;

  // ioInputs = {ioSelect, ioWrite, bank[depth-1:0], data[W-1:0]}
  function automatic int unsigned io_bank_lsb(input int unsigned w);
    return w;
  endfunction

  function automatic int unsigned io_write_bit(input int unsigned w, input int unsigned depth);
    return w + depth;
  endfunction

  function automatic int unsigned io_select_bit(input int unsigned w, input int unsigned depth);
    return w + depth + 1;
  endfunction

endpackage

// File: rtl/kb_row_counter.sv
// Loadable wrapping row address with a down-counted row budget; shared by load and read walks.
module kb_row_counter #(
  parameter int unsigned A = 7
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [A-1:0] i_base,
  input  logic [A:0]   i_rows,
  input  logic         i_step,
  output logic [A-1:0] o_row,
  output logic         o_last
);

  logic [A-1:0] r_row;
  logic [A:0]   r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_row   <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_row   <= i_base;
      r_count <= i_rows;
    end else if (i_step) begin
      r_row   <= r_row + 1'b1;
      r_count <= r_count - 1'b1;
    end
  end

  assign o_row  = r_row;
  assign o_last = (r_count == {{A{1'b0}}, 1'b1});

endmodule

// File: rtl/kernel_buffer_ctrl.sv
// Kernel buffer sequencer: round-robin bank writes from a word stream, then a stallable
// row-address walk for the convolution unit.
module kernel_buffer_ctrl
  import kernel_buffer_pkg::*;
#(
  parameter int unsigned depth = 2,
  parameter int unsigned A     = 7,
  parameter int unsigned W     = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 load_start,
  input  logic [A-1:0]         load_base,
  input  logic [A:0]           load_rows,
  input  logic [W-1:0]         in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 read_start,
  input  logic [A-1:0]         read_base,
  input  logic [A:0]           read_rows,
  input  logic                 read_advance,
  output logic [A-1:0]         address,
  output logic [W+depth+1:0]   ioInputs,
  output logic                 row_valid,
  output logic                 load_done,
  output logic                 read_done,
  output logic                 busy
);

  localparam int unsigned BankLsb   = io_bank_lsb(W);
  localparam int unsigned WriteBit  = io_write_bit(W, depth);
  localparam int unsigned SelectBit = io_select_bit(W, depth);

  kb_state_e          r_state;
  logic [depth-1:0]   r_bank;
  logic [A-1:0]       r_address;
  logic [W+depth+1:0] r_io;
  logic               r_row_valid;
  logic               r_load_done;
  logic               r_read_done;

  logic               w_load_hs;
  logic               w_bank_wrap;
  logic               w_cnt_load;
  logic               w_cnt_step;
  logic [A-1:0]       w_cnt_base;
  logic [A:0]         w_cnt_rows;
  logic [A-1:0]       w_row;
  logic               w_last;
  logic [W+depth+1:0] w_write_word;

  assign in_ready    = (r_state == StLoad);
  assign busy        = (r_state != StIdle);
  assign w_load_hs   = in_valid & in_ready;
  assign w_bank_wrap = &r_bank;

  // Load wins when both starts arrive together, so the counter follows the same priority.
  assign w_cnt_load = (r_state == StIdle) & (load_start | read_start);
  assign w_cnt_base = load_start ? load_base : read_base;
  assign w_cnt_rows = load_start ? load_rows : read_rows;
  assign w_cnt_step = ((r_state == StLoad) & w_load_hs & w_bank_wrap) |
                      ((r_state == StRead) & read_advance);

  kb_row_counter #(
    .A(A)
  ) u_row_counter (
    .i_clk (CLK),
    .i_rst (RST),
    .i_load(w_cnt_load),
    .i_base(w_cnt_base),
    .i_rows(w_cnt_rows),
    .i_step(w_cnt_step),
    .o_row (w_row),
    .o_last(w_last)
  );

  always_comb begin
    w_write_word                      = '0;
    w_write_word[W-1:0]               = in_data;
    w_write_word[BankLsb +: depth]    = r_bank;
    w_write_word[WriteBit]            = 1'b1;
    w_write_word[SelectBit]           = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= StIdle;
      r_bank      <= '0;
      r_address   <= '0;
      r_io        <= '0;
      r_row_valid <= 1'b0;
      r_load_done <= 1'b0;
      r_read_done <= 1'b0;
    end else begin
      // Strobes and the write word live for exactly one cycle unless re-issued.
      r_io        <= '0;
      r_row_valid <= 1'b0;
      r_load_done <= 1'b0;
      r_read_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (load_start) begin
            r_bank <= '0;
            if (load_rows == '0) r_load_done <= 1'b1;
            else                 r_state     <= StLoad;
          end else if (read_start) begin
            if (read_rows == '0) begin
              r_read_done <= 1'b1;
            end else begin
              r_state   <= StRead;
              r_address <= read_base;
            end
          end
        end
        StLoad: begin
          if (w_load_hs) begin
            r_io      <= w_write_word;
            r_address <= w_row;
            r_bank    <= r_bank + 1'b1;
            if (w_bank_wrap && w_last) begin
              r_state     <= StLoadFlush;
              r_load_done <= 1'b1;
            end
          end
        end
        StLoadFlush: r_state <= StIdle;
        StRead: begin
          if (read_advance) begin
            r_row_valid <= 1'b1;
            r_address   <= w_row + 1'b1;
            if (w_last) begin
              r_state     <= StDrain;
              r_read_done <= 1'b1;
            end
          end
        end
        StDrain: r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign address   = r_address;
  assign ioInputs  = r_io;
  assign row_valid = r_row_valid;
  assign load_done = r_load_done;
  assign read_done = r_read_done;

endmodule
